dvi_pattern_ctrl: RTL

// - Run-time configuration controller for the DVI test-pattern generator. Sits between board buttons and the video core.
// - Debounces next/prev buttons and keeps a pending pattern index.
// - Applies a new index only on a frame boundary (vsync rising edge).
// - Drives a mute request around each change so the generator blanks instead of tearing.

---
 rtl/dvi_pattern_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dvi_pattern_ctrl.sv
// Run-time pattern selector for the DVI test-pattern generator: debounced next/prev buttons,
// frame-aligned pattern switching with a mute window. Define AUTO_CYCLE_EN for frame-count auto-advance.
module dvi_pattern_ctrl #(
  parameter int unsigned C_PATTERNS      = 8,
  parameter int unsigned C_DEBOUNCE_BITS = 16,
  parameter int unsigned C_MUTE_FRAMES   = 2,
  parameter int unsigned C_AUTO_FRAMES   = 300,
  localparam int unsigned PW = (C_PATTERNS > 2) ? $clog2(C_PATTERNS) : 1
) (
  input  logic          clk_pixel,
  input  logic          resetn,
  input  logic          btn_next,
  input  logic          btn_prev,
  input  logic          vsync,
  output logic [PW-1:0] pattern,
  output logic          mute,
  output logic          update_strobe,
  output logic [7:0]    led
);

  localparam int unsigned LW = (PW > 6) ? PW : 6;
  localparam logic [C_DEBOUNCE_BITS-1:0] DB_MAX = '1;
  localparam logic [PW-1:0] PAT_LAST = PW'(C_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_MUTE  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    sync1, sync2, sync3;
  logic [1:0]    press;
  logic [PW-1:0] pending;
  logic          vsync_d;
  logic          vsync_rise_c;
  logic          next_evt_c;
  logic          prev_evt_c;
  logic [7:0]    frame_cnt;
  logic          first_rise;
  logic [LW-1:0] pattern_ext;

  // Two-flop synchronizers for both buttons, plus one extra stage to detect level changes.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {btn_prev, btn_next};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Per-button debounce: level is accepted only after the counter saturates; press on accepted rise.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [C_DEBOUNCE_BITS-1:0] cnt;
    logic                       level;
    logic                       press_q;

    always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
        cnt     <= '0;
        level   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (sync2[i] != sync3[i]) begin
          cnt <= '0;
        end else if (cnt != DB_MAX) begin
          cnt <= cnt + C_DEBOUNCE_BITS'(1);
        end else if (level != sync3[i]) begin
          level   <= sync3[i];
          press_q <= sync3[i];
        end
      end
    end

    assign press[i] = press_q;
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
    end
  end

  assign vsync_rise_c = vsync & ~vsync_d;
  assign prev_evt_c   = press[1];

`ifdef AUTO_CYCLE_EN
  localparam int unsigned AW = $clog2(C_AUTO_FRAMES + 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_hit_c;
  logic          auto_fire_c;

  // Counts frame boundaries seen while idle; a button press resets the count and wins over auto.
  assign auto_hit_c  = (state == S_IDLE) && vsync_rise_c && (auto_cnt == AW'(C_AUTO_FRAMES - 1));
  assign auto_fire_c = auto_hit_c && (press == 2'b00);
  assign next_evt_c  = press[0] | auto_fire_c;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      auto_cnt <= '0;
    end else if (press != 2'b00) begin
      auto_cnt <= '0;
    end else if ((state == S_IDLE) && vsync_rise_c) begin
      auto_cnt <= auto_hit_c ? '0 : auto_cnt + AW'(1);
    end
  end
`else
  assign next_evt_c = press[0];
`endif

  // Pending index with wrap-around; coincident next and prev cancel out.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else if (next_evt_c && !prev_evt_c) begin
      pending <= (pending == PAT_LAST) ? '0 : pending + PW'(1);
    end else if (prev_evt_c && !next_evt_c) begin
      pending <= (pending == '0) ? PAT_LAST : pending - PW'(1);
    end
  end

  // Switch sequencer: arm on a pending change, mute at the next frame, apply one frame later.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      pattern       <= '0;
      mute          <= 1'b0;
      update_strobe <= 1'b0;
      frame_cnt     <= '0;
      first_rise    <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending != pattern) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (vsync_rise_c) begin
            mute       <= 1'b1;
            frame_cnt  <= 8'(C_MUTE_FRAMES);
            first_rise <= 1'b1;
            state      <= S_MUTE;
          end
        end
        S_MUTE: begin
          if (vsync_rise_c) begin
            frame_cnt  <= frame_cnt - 8'd1;
            first_rise <= 1'b0;
            if (first_rise) begin
              pattern       <= pending;
              update_strobe <= 1'b1;
            end
            if (frame_cnt == 8'd1) begin
              mute  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign pattern_ext = LW'(pattern);

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      led <= '0;
    end else begin
      led <= {mute, (state == S_ARMED), pattern_ext[5:0]};
    end
  end

endmodule
